// File: rtl/axi_lite_sram_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram_master
// Purpose  : AXI4-Lite slave front end that drives a single-port SRAM as its
//            initiator. Each AXI transaction becomes at most one SRAM access.
//            AXI byte addresses are turned into SRAM word indices. Write
//            responses come from the SRAM resp pulse and are protected by a
//            timeout.
// Ports    : clk/resetn          - clock, asynchronous active-low reset
//            s_aw*/s_w*/s_b*     - AXI4-Lite write address/data/response
//            s_ar*/s_r*          - AXI4-Lite read address/data
//            sram_*              - SRAM initiator port (write_en active low)
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram_master #(
    parameter int DEPTH_LOG2 = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_w_data,
    output logic        sram_chip_select,
    output logic        sram_write_en,
    input  logic [31:0] sram_r_data,
    input  logic        sram_resp
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [7:0] LAST_WAIT   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        WR_RESP  = 3'd3,
        RD_ISSUE = 3'd4,
        RD_RESP  = 3'd5
    } state_t;

    state_t      state_q;
    logic        prio_q;        // 0: write wins a tie, 1: read wins a tie
    logic [7:0]  wait_cnt_q;
    logic        cs_q;
    logic        we_n_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  bresp_q;
    logic [1:0]  rresp_q;
    logic        bvalid_q;
    logic        rvalid_q;

    logic w_idle;
    logic w_wr_elig;
    logic w_rd_elig;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_aw_oor;
    logic w_ar_oor;
    logic w_unused_addr_lsbs;

    // Readys are combinational; gating with resetn keeps them low while the
    // reset is held even though the state register already reads IDLE.
    assign w_idle     = (state_q == IDLE) & resetn;
    assign w_wr_elig  = s_awvalid & s_wvalid;
    assign w_rd_elig  = s_arvalid;
    assign w_grant_wr = w_idle & w_wr_elig & (~w_rd_elig | ~prio_q);
    assign w_grant_rd = w_idle & w_rd_elig & (~w_wr_elig | prio_q);

    // Any set bit above the word-index field means the SRAM is not addressed.
    assign w_aw_oor = |s_awaddr[31:DEPTH_LOG2+2];
    assign w_ar_oor = |s_araddr[31:DEPTH_LOG2+2];

    // Byte-lane bits are deliberately dropped: unaligned accesses act aligned.
    assign w_unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready        = w_grant_wr;
    assign s_wready         = w_grant_wr;
    assign s_arready        = w_grant_rd;
    assign s_bresp          = bresp_q;
    assign s_bvalid         = bvalid_q;
    assign s_rdata          = rdata_q;
    assign s_rresp          = rresp_q;
    assign s_rvalid         = rvalid_q;
    assign sram_address     = addr_q;
    assign sram_w_data      = wdata_q;
    assign sram_chip_select = cs_q;
    assign sram_write_en    = we_n_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            wait_cnt_q <= 8'd0;
            cs_q       <= 1'b0;
            we_n_q     <= 1'b1;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_grant_wr) begin
                        prio_q <= ~prio_q;
                        if (w_aw_oor) begin
                            bresp_q  <= RESP_DECERR;
                            bvalid_q <= 1'b1;
                            state_q  <= WR_RESP;
                        end else if (s_wstrb != 4'hF) begin
                            bresp_q  <= RESP_SLVERR;
                            bvalid_q <= 1'b1;
                            state_q  <= WR_RESP;
                        end else begin
                            addr_q  <= {2'b00, s_awaddr[31:2]};
                            wdata_q <= s_wdata;
                            cs_q    <= 1'b1;
                            we_n_q  <= 1'b0;
                            state_q <= WR_ISSUE;
                        end
                    end else if (w_grant_rd) begin
                        prio_q <= ~prio_q;
                        if (w_ar_oor) begin
                            rresp_q  <= RESP_DECERR;
                            rdata_q  <= 32'd0;
                            rvalid_q <= 1'b1;
                            state_q  <= RD_RESP;
                        end else begin
                            addr_q  <= {2'b00, s_araddr[31:2]};
                            cs_q    <= 1'b1;
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    cs_q       <= 1'b0;
                    we_n_q     <= 1'b1;
                    wait_cnt_q <= 8'd0;
                    state_q    <= WR_WAIT;
                end
                WR_WAIT: begin
                    // A resp arriving on the final allowed cycle still wins.
                    if (sram_resp) begin
                        bresp_q  <= RESP_OKAY;
                        bvalid_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        bresp_q  <= RESP_SLVERR;
                        bvalid_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                WR_RESP: begin
                    if (s_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    cs_q     <= 1'b0;
                    rdata_q  <= sram_r_data;
                    rresp_q  <= RESP_OKAY;
                    rvalid_q <= 1'b1;
                    state_q  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
